// File: rtl/rvfi_gen_pkg.sv
// Shared types for the RVFI retirement generator: the buffered instruction record
// and the fixed widths/bit positions used by the top level.
package rvfi_gen_pkg;

    localparam int REC_XLEN  = 32;
    localparam int ORDER_W   = 64;
    localparam int FAULT_BIT = 2;

    typedef struct packed {
        logic [REC_XLEN-1:0] pc_rdata;
        logic [REC_XLEN-1:0] pc_wdata;
    } rec_t;

endpackage

// File: rtl/rvfi_gen_fifo.sv
// Record buffer with single push and 0..NRET pop per cycle. The oldest NRET entries
// are always visible on head[] so the top can retire several at once.
module rvfi_gen_fifo
    import rvfi_gen_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NRET  = 2,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int KW    = $clog2(NRET + 1)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          push,
    input  rec_t          push_data,
    input  logic [KW-1:0] pop_cnt,
    output rec_t          head [NRET],
    output logic [AW:0]   count,
    output logic          full
);

    localparam int MEM = 1 << AW;

    rec_t        mem [MEM];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Pointers carry one extra wrap bit, so the difference is the occupancy.
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));

    always_comb begin
        for (int j = 0; j < NRET; j++) begin
            head[j] = mem[AW'(rd_ptr + (AW+1)'(j))];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            rd_ptr <= rd_ptr + (AW+1)'(pop_cnt);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/rvfi_pc_chain_gen.sv
// RVFI retirement transmitter: buffers PC records and retires up to NRET per cycle
// with consecutive orders and a sticky PC-chain monitor. RVFI_GEN_FAULT_EN adds fault_inj.
module rvfi_pc_chain_gen
    import rvfi_gen_pkg::*;
#(
    parameter int XLEN       = REC_XLEN,
    parameter int NRET       = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc_rdata,
    input  logic [XLEN-1:0]         in_pc_wdata,
    input  logic                    hold,
    output logic [NRET-1:0]         rvfi_valid,
    output logic [ORDER_W*NRET-1:0] rvfi_order,
    output logic [XLEN*NRET-1:0]    rvfi_pc_rdata,
    output logic [XLEN*NRET-1:0]    rvfi_pc_wdata,
    output logic                    chain_err
`ifdef RVFI_GEN_FAULT_EN
    ,
    input  logic                    fault_inj
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int KW = $clog2(NRET + 1);
    localparam int CW = AW + 1;

    rec_t          in_rec;
    rec_t          head [NRET];
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          push;
    logic [KW-1:0] pop_cnt;

    logic [ORDER_W-1:0] order_cnt;
    logic [XLEN-1:0]    last_pc;
    logic               last_valid;

    logic [NRET-1:0]         nxt_valid;
    logic [ORDER_W*NRET-1:0] nxt_order;
    logic [XLEN*NRET-1:0]    nxt_rd;
    logic [XLEN*NRET-1:0]    nxt_wd;
    logic                    nxt_err;
    logic [XLEN-1:0]         pred_pc;
    logic                    pred_ok;

    // valid/ready: a record transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on registered occupancy, never on this cycle's pop.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign in_rec   = '{pc_rdata: in_pc_rdata, pc_wdata: in_pc_wdata};

    rvfi_gen_fifo #(
        .DEPTH (FIFO_DEPTH),
        .NRET  (NRET)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (push),
        .push_data (in_rec),
        .pop_cnt   (pop_cnt),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    always_comb begin
        pop_cnt = '0;
        if (!hold) begin
            pop_cnt = (fifo_count >= CW'(NRET)) ? KW'(NRET) : KW'(fifo_count);
        end
    end

    // Pack retiring records low-aligned; each one is checked against its predecessor,
    // which is last_pc for channel 0 and the previous channel otherwise.
    always_comb begin
        nxt_valid = '0;
        nxt_order = '0;
        nxt_rd    = '0;
        nxt_wd    = '0;
        nxt_err   = chain_err;
        pred_pc   = last_pc;
        pred_ok   = last_valid;
        for (int j = 0; j < NRET; j++) begin
            if (KW'(j) < pop_cnt) begin
                nxt_valid[j]                    = 1'b1;
                nxt_order[j*ORDER_W +: ORDER_W] = order_cnt + ORDER_W'(j);
                nxt_rd[j*XLEN +: XLEN]          = head[j].pc_rdata;
                nxt_wd[j*XLEN +: XLEN]          = head[j].pc_wdata;
                if (pred_ok && (head[j].pc_rdata != pred_pc)) begin
                    nxt_err = 1'b1;
                end
                pred_pc = head[j].pc_wdata;
                pred_ok = 1'b1;
            end
        end
    end

`ifdef RVFI_GEN_FAULT_EN
    logic fault_pend;
    logic nxt_pend;
    logic [XLEN*NRET-1:0] out_rd;

    // Corruption touches only the outgoing copy; the monitor above saw the clean value.
    always_comb begin
        out_rd   = nxt_rd;
        nxt_pend = fault_pend;
        if (fault_pend && (pop_cnt != '0)) begin
            out_rd[FAULT_BIT] = ~nxt_rd[FAULT_BIT];
            nxt_pend          = 1'b0;
        end
        if (fault_inj && !fault_pend) begin
            nxt_pend = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fault_pend <= 1'b0;
        end else begin
            fault_pend <= nxt_pend;
        end
    end
`else
    logic [XLEN*NRET-1:0] out_rd;
    assign out_rd = nxt_rd;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            order_cnt     <= '0;
            rvfi_valid    <= '0;
            rvfi_order    <= '0;
            rvfi_pc_rdata <= '0;
            rvfi_pc_wdata <= '0;
            last_pc       <= '0;
            last_valid    <= 1'b0;
            chain_err     <= 1'b0;
        end else begin
            order_cnt     <= order_cnt + ORDER_W'(pop_cnt);
            rvfi_valid    <= nxt_valid;
            rvfi_order    <= nxt_order;
            rvfi_pc_rdata <= out_rd;
            rvfi_pc_wdata <= nxt_wd;
            last_pc       <= pred_pc;
            last_valid    <= pred_ok;
            chain_err     <= nxt_err;
        end
    end

endmodule

// File: tb/tb_rvfi_pc_chain_gen.sv
// Bench for rvfi_pc_chain_gen: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a record-stream model.
module tb_rvfi_pc_chain_gen;

    localparam int XLEN  = 32;
    localparam int NRET  = 2;
    localparam int DEPTH = 4;

    logic                 clock = 1'b0;
    logic                 resetn = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 hold = 1'b0;
    logic [XLEN-1:0]      in_pc_rdata = '0;
    logic [XLEN-1:0]      in_pc_wdata = '0;
    logic                 in_ready;
    logic [NRET-1:0]      rvfi_valid;
    logic [64*NRET-1:0]   rvfi_order;
    logic [XLEN*NRET-1:0] rvfi_pc_rdata;
    logic [XLEN*NRET-1:0] rvfi_pc_wdata;
    logic                 chain_err;
`ifdef RVFI_GEN_FAULT_EN
    logic                 fault_inj = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    rvfi_pc_chain_gen #(
        .XLEN       (XLEN),
        .NRET       (NRET),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc_rdata   (in_pc_rdata),
        .in_pc_wdata   (in_pc_wdata),
        .hold          (hold),
        .rvfi_valid    (rvfi_valid),
        .rvfi_order    (rvfi_order),
        .rvfi_pc_rdata (rvfi_pc_rdata),
        .rvfi_pc_wdata (rvfi_pc_wdata),
        .chain_err     (chain_err)
`ifdef RVFI_GEN_FAULT_EN
        ,
        .fault_inj     (fault_inj)
`endif
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic do_reset();
        @(negedge clock);
        #2 resetn = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        #2 resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending records, a running order number and the
    // last retired next-PC of the whole stream.
    logic [63:0]     exp_q[$];
    logic [63:0]     m_order;
    logic [XLEN-1:0] m_last_pc;
    logic            m_last_valid;
    logic            m_err;
    logic [NRET-1:0] e_valid;
    logic [63:0]     e_order [NRET];
    logic [XLEN-1:0] e_rd [NRET];
    logic [XLEN-1:0] e_wd [NRET];
    int              m_k;
    logic            m_acc;
    logic [63:0]     m_rec;
`ifdef RVFI_GEN_FAULT_EN
    logic            m_pend;
    logic            m_old_pend;
`endif

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            exp_q.delete();
            m_order      = '0;
            m_last_pc    = '0;
            m_last_valid = 1'b0;
            m_err        = 1'b0;
            e_valid      = '0;
            for (int j = 0; j < NRET; j++) begin
                e_order[j] = '0;
                e_rd[j]    = '0;
                e_wd[j]    = '0;
            end
`ifdef RVFI_GEN_FAULT_EN
            m_pend = 1'b0;
`endif
        end else begin
            m_acc = in_valid && (exp_q.size() < DEPTH);
            m_k   = hold ? 0 : ((exp_q.size() < NRET) ? exp_q.size() : NRET);
            e_valid = '0;
            for (int j = 0; j < NRET; j++) begin
                e_order[j] = '0;
                e_rd[j]    = '0;
                e_wd[j]    = '0;
            end
            for (int j = 0; j < m_k; j++) begin
                m_rec      = exp_q.pop_front();
                e_valid[j] = 1'b1;
                e_order[j] = m_order;
                m_order    = m_order + 64'd1;
                e_rd[j]    = m_rec[63:32];
                e_wd[j]    = m_rec[31:0];
                if (m_last_valid && (m_rec[63:32] != m_last_pc)) m_err = 1'b1;
                m_last_pc    = m_rec[31:0];
                m_last_valid = 1'b1;
            end
`ifdef RVFI_GEN_FAULT_EN
            m_old_pend = m_pend;
            if (m_old_pend && m_k > 0) begin
                e_rd[0] = e_rd[0] ^ 32'h4;
                m_pend  = 1'b0;
            end
            if (fault_inj && !m_old_pend) m_pend = 1'b1;
`endif
            if (m_acc) exp_q.push_back({in_pc_rdata, in_pc_wdata});
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge clock) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
            chk("rvfi_valid", 64'(rvfi_valid), 64'(e_valid));
            for (int j = 0; j < NRET; j++) begin
                chk($sformatf("order[%0d]", j), rvfi_order[j*64 +: 64], e_order[j]);
                chk($sformatf("pc_rdata[%0d]", j), 64'(rvfi_pc_rdata[j*XLEN +: XLEN]), 64'(e_rd[j]));
                chk($sformatf("pc_wdata[%0d]", j), 64'(rvfi_pc_wdata[j*XLEN +: XLEN]), 64'(e_wd[j]));
            end
            chk("chain_err", 64'(chain_err), 64'(m_err));
        end
    end

    // drivers (called on a falling edge, return on a falling edge)
    task automatic push(input logic [XLEN-1:0] rd, input logic [XLEN-1:0] wd);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) begin
            chk("push_timeout", 64'(in_ready), 64'd1);
        end else begin
            in_valid    = 1'b1;
            in_pc_rdata = rd;
            in_pc_wdata = wd;
            @(negedge clock);
            in_valid = 1'b0;
        end
    endtask

    task automatic rand_seg(input int ncyc);
        logic [XLEN-1:0] chain_pc = 32'h1000;
        for (int c = 0; c < ncyc; c++) begin
            hold        = ($urandom_range(0, 3) == 0);
            in_valid    = ($urandom_range(0, 9) < 7);
            in_pc_rdata = ($urandom_range(0, 15) == 0) ? chain_pc + 32'h100 : chain_pc;
            in_pc_wdata = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC)
                                                      : in_pc_rdata + 32'h4;
`ifdef RVFI_GEN_FAULT_EN
            fault_inj   = ($urandom_range(0, 19) == 0);
`endif
            if (in_valid && in_ready) chain_pc = in_pc_wdata;
            @(negedge clock);
        end
        in_valid = 1'b0;
        hold     = 1'b0;
`ifdef RVFI_GEN_FAULT_EN
        fault_inj = 1'b0;
`endif
        repeat (4) @(negedge clock);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: actual=running required=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        repeat (2) @(negedge clock);
        #2 resetn = 1'b1;
        @(negedge clock);
        chk_en = 1'b1;

        // reset state
        chk("rst_valid", 64'(rvfi_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_chain_err", 64'(chain_err), 64'd0);

        // three chained records, two then one retire
        hold = 1'b1;
        push(32'h0, 32'h4);
        push(32'h4, 32'h8);
        push(32'h8, 32'hC);
        hold = 1'b0;
        @(negedge clock);
        chk("t1_valid_a", 64'(rvfi_valid), 64'h3);
        chk("t1_order0", rvfi_order[63:0], 64'd0);
        chk("t1_order1", rvfi_order[127:64], 64'd1);
        chk("t1_rd1", 64'(rvfi_pc_rdata[63:32]), 64'h4);
        @(negedge clock);
        chk("t1_valid_b", 64'(rvfi_valid), 64'h1);
        chk("t1_order_c", rvfi_order[63:0], 64'd2);
        chk("t1_rd_c", 64'(rvfi_pc_rdata[31:0]), 64'h8);
        chk("t1_ch1_idle", rvfi_order[127:64], 64'd0);
        chk("t1_err", 64'(chain_err), 64'd0);

        // fill while held, then drain two per cycle
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4*i), 32'h104 + 32'(4*i));
        chk("t2_full", 64'(in_ready), 64'd0);
        hold = 1'b0;
        @(negedge clock);
        chk("t2_valid_a", 64'(rvfi_valid), 64'h3);
        chk("t2_orders_a", {rvfi_order[95:64], rvfi_order[31:0]}, {32'd1, 32'd0});
        chk("t2_ready_back", 64'(in_ready), 64'd1);
        @(negedge clock);
        chk("t2_valid_b", 64'(rvfi_valid), 64'h3);
        chk("t2_orders_b", {rvfi_order[95:64], rvfi_order[31:0]}, {32'd3, 32'd2});

        // broken chain through last_pc
        do_reset();
        push(32'h0, 32'h8);
        push(32'h10, 32'h14);
        chk("t3_first_ok", 64'(chain_err), 64'd0);
        @(negedge clock);
        chk("t3_rd", 64'(rvfi_pc_rdata[31:0]), 64'h10);
        chk("t3_err_set", 64'(chain_err), 64'd1);
        repeat (3) @(negedge clock);
        chk("t3_err_sticky", 64'(chain_err), 64'd1);

        // order counter wrap
        do_reset();
        hold = 1'b1;
        force dut.order_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.order_cnt;
        m_order = 64'hFFFF_FFFF_FFFF_FFFF;
        push(32'h200, 32'h204);
        push(32'h204, 32'h208);
        hold = 1'b0;
        @(negedge clock);
        chk("t4_order_max", rvfi_order[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t4_order_wrap", rvfi_order[127:64], 64'd0);

        // asynchronous reset with records buffered
        do_reset();
        hold = 1'b1;
        push(32'h20, 32'h24);
        push(32'h24, 32'h28);
        push(32'h28, 32'h2C);
        hold = 1'b0;
        @(posedge clock);
        #2;
        chk("t5_pre_valid", 64'(rvfi_valid), 64'h3);
        resetn = 1'b0;
        #1;
        chk("t5_async_valid", 64'(rvfi_valid), 64'd0);
        chk("t5_async_ready", 64'(in_ready), 64'd1);
        @(negedge clock);
        #2 resetn = 1'b1;
        @(negedge clock);
        push(32'h40, 32'h44);
        @(negedge clock);
        chk("t5_valid", 64'(rvfi_valid), 64'h1);
        chk("t5_order", rvfi_order[63:0], 64'd0);
        chk("t5_rd", 64'(rvfi_pc_rdata[31:0]), 64'h40);

`ifdef RVFI_GEN_FAULT_EN
        // corrupted retire
        do_reset();
        fault_inj = 1'b1;
        @(negedge clock);
        fault_inj = 1'b0;
        push(32'h4, 32'h8);
        @(negedge clock);
        chk("t6_rd_flip", 64'(rvfi_pc_rdata[31:0]), 64'h0);
        chk("t6_err", 64'(chain_err), 64'd0);
        push(32'h8, 32'hC);
        @(negedge clock);
        chk("t6_rd_clean", 64'(rvfi_pc_rdata[31:0]), 64'h8);
        chk("t6_err_after", 64'(chain_err), 64'd0);
`endif

        // randomized traffic
        for (int s = 0; s < 4; s++) begin
            do_reset();
            rand_seg(150);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
